// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared stage tag, forward select and kill mask definitions
package pipeline_pkg;

    // Tags carry rd at a fixed width; register numbers narrower than this are zero-extended.
    localparam int MAX_REG_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [MAX_REG_W-1:0] rd;
        logic                 wr;
        logic                 ld;
    } stage_tag_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_S2 = 2'd1,
        FWD_S3 = 2'd2,
        FWD_S4 = 2'd3
    } fwd_sel_t;

    localparam logic [3:0] KILL_NONE  = 4'b0000;
    localparam logic [3:0] KILL_STALL = 4'b0010;
    localparam logic [3:0] KILL_FLUSH = 4'b0111;

    localparam stage_tag_t BUBBLE = '0;

    function automatic logic producer_hit(input stage_tag_t tag, input logic [MAX_REG_W-1:0] src);
        return tag.valid && tag.wr && (tag.rd == src);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - per-operand producer compare, youngest-first select and data mux
module operand_fwd_mux
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              s1_valid,
    input  logic              src_use,
    input  logic [REG_W-1:0]  src,
    input  stage_tag_t        s2,
    input  stage_tag_t        s3,
    input  stage_tag_t        s4,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] res_s2,
    input  logic [DATA_W-1:0] res_s3,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] data,
    output logic              load_hit
);

    logic [MAX_REG_W-1:0] src_ext;
    logic                 hit2, hit3, hit4;
    fwd_sel_t             sel_e;
    logic                 unused_s4_ld;

    assign src_ext      = MAX_REG_W'(src);
    assign hit2         = s1_valid && src_use && producer_hit(s2, src_ext);
    assign hit3         = s1_valid && src_use && producer_hit(s3, src_ext);
    assign hit4         = s1_valid && src_use && producer_hit(s4, src_ext);
    assign unused_s4_ld = s4.ld;

    // A load still in S2 or S3 has no data yet, regardless of younger matches.
    assign load_hit = (hit2 && s2.ld) || (hit3 && s3.ld);

    always_comb begin
        sel_e = FWD_RF;
        data  = rf_data;
        if (hit2) begin
            sel_e = FWD_S2;
            data  = res_s2;
        end else if (hit3) begin
            sel_e = FWD_S3;
            data  = res_s3;
        end else if (hit4) begin
            sel_e = FWD_S4;
            data  = wb_data;
        end
    end

    assign sel = sel_e;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stage tag tracking, operand forwarding, load-use stall and flush control
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    parameter int NUM_OPS = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dec_valid,
    input  logic [NUM_OPS*REG_W-1:0]  dec_src,
    input  logic [NUM_OPS-1:0]        dec_src_use,
    input  logic [REG_W-1:0]          dec_rd,
    input  logic                      dec_wr,
    input  logic                      dec_ld,
    input  logic                      flush_in,
    input  logic [NUM_OPS*DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0]         res_s2,
    input  logic [DATA_W-1:0]         res_s3,
    input  logic [DATA_W-1:0]         wb_data,
    output logic [NUM_OPS*DATA_W-1:0] op_data,
    output logic [NUM_OPS*2-1:0]      op_sel,
    output logic                      update_s1,
    output logic [4:1]                kill,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    stage_tag_t                 s1, s2, s3, s4;
    stage_tag_t                 dec_tag;
    logic [NUM_OPS*REG_W-1:0]   s1_src;
    logic [NUM_OPS-1:0]         s1_use;
    logic [NUM_OPS-1:0]         load_hit;
    logic                       flush;
    logic                       stall;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        operand_fwd_mux #(
            .DATA_W (DATA_W),
            .REG_W  (REG_W)
        ) u_fwd (
            .s1_valid (s1.valid),
            .src_use  (s1_use[g]),
            .src      (s1_src[g*REG_W +: REG_W]),
            .s2       (s2),
            .s3       (s3),
            .s4       (s4),
            .rf_data  (rf_data[g*DATA_W +: DATA_W]),
            .res_s2   (res_s2),
            .res_s3   (res_s3),
            .wb_data  (wb_data),
            .sel      (op_sel[g*2 +: 2]),
            .data     (op_data[g*DATA_W +: DATA_W]),
            .load_hit (load_hit[g])
        );
    end

    // Gating with rst_n keeps kill/update_s1 at their idle values throughout reset.
    assign flush     = rst_n && flush_in;
    assign stall     = rst_n && (|load_hit) && !flush_in;
    assign update_s1 = !stall;
    assign kill      = flush ? KILL_FLUSH : (stall ? KILL_STALL : KILL_NONE);

    assign dec_tag = '{valid: dec_valid, rd: MAX_REG_W'(dec_rd), wr: dec_wr, ld: dec_ld};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= BUBBLE;
            s2        <= BUBBLE;
            s3        <= BUBBLE;
            s4        <= BUBBLE;
            s1_src    <= '0;
            s1_use    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            s4 <= s3;
            if (flush) begin
                s1 <= BUBBLE;
                s2 <= BUBBLE;
                s3 <= BUBBLE;
                if (!(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
            end else if (stall) begin
                s2 <= BUBBLE;
                s3 <= s2;
                if (!(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            end else begin
                s1     <= dec_tag;
                s1_src <= dec_src;
                s1_use <= dec_src_use;
                s2     <= s1;
                s3     <= s2;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized and directed checks of pipeline_hazard_ctrl against a stage-array model
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic [8:0]  dec_src = '0;
    logic [2:0]  dec_src_use = '0;
    logic [2:0]  dec_rd = '0;
    logic        dec_wr = 1'b0;
    logic        dec_ld = 1'b0;
    logic        flush_in = 1'b0;
    logic [47:0] rf_data = '0;
    logic [15:0] res_s2 = '0;
    logic [15:0] res_s3 = '0;
    logic [15:0] wb_data = '0;

    logic [47:0] op_data, op_data_s;
    logic [5:0]  op_sel, op_sel_s;
    logic        update_s1, update_s1_s;
    logic [4:1]  kill, kill_s;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt_s, flush_cnt_s;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_src_use(dec_src_use), .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_ld(dec_ld),
        .flush_in(flush_in), .rf_data(rf_data), .res_s2(res_s2), .res_s3(res_s3),
        .wb_data(wb_data), .op_data(op_data), .op_sel(op_sel), .update_s1(update_s1),
        .kill(kill), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_src_use(dec_src_use), .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_ld(dec_ld),
        .flush_in(flush_in), .rf_data(rf_data), .res_s2(res_s2), .res_s3(res_s3),
        .wb_data(wb_data), .op_data(op_data_s), .op_sel(op_sel_s), .update_s1(update_s1_s),
        .kill(kill_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    always #5 clk = ~clk;

    // Model: one entry per stage 1..4, plus the operands of whatever sits in S1.
    bit       m_valid [1:4];
    bit [2:0] m_rd    [1:4];
    bit       m_wr    [1:4];
    bit       m_ld    [1:4];
    bit [2:0] m_src   [0:2];
    bit       m_use   [0:2];
    int       m_stall_n;
    int       m_flush_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_match(int k, int i);
        return m_valid[1] && m_use[i] && m_valid[k] && m_wr[k] && (m_rd[k] == m_src[i]);
    endfunction

    function automatic bit m_stall();
        bit s = 0;
        if (!rst_n || flush_in) return 0;
        for (int i = 0; i < 3; i++)
            for (int k = 2; k <= 3; k++)
                if (m_match(k, i) && m_ld[k]) s = 1;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= 4; k++) m_valid[k] = 0;
        m_stall_n = 0;
        m_flush_n = 0;
    endtask

    task automatic model_update();
        bit st;
        st = m_stall();
        if (!rst_n) begin
            model_reset();
        end else if (flush_in) begin
            m_flush_n++;
            m_valid[4] = m_valid[3]; m_rd[4] = m_rd[3]; m_wr[4] = m_wr[3]; m_ld[4] = m_ld[3];
            for (int k = 1; k <= 3; k++) m_valid[k] = 0;
        end else begin
            for (int k = 4; k >= 2; k--) begin
                if (st && k == 2) begin
                    m_valid[2] = 0;
                end else begin
                    m_valid[k] = m_valid[k-1]; m_rd[k] = m_rd[k-1];
                    m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
                end
            end
            if (st) begin
                m_stall_n++;
            end else begin
                m_valid[1] = dec_valid; m_rd[1] = dec_rd; m_wr[1] = dec_wr; m_ld[1] = dec_ld;
                for (int i = 0; i < 3; i++) begin
                    m_src[i] = dec_src[i*3 +: 3];
                    m_use[i] = dec_src_use[i];
                end
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] res [2:4];
        logic [1:0]  esel;
        logic [15:0] edata;
        bit          st;
        res[2] = res_s2; res[3] = res_s3; res[4] = wb_data;
        st = m_stall();
        for (int i = 0; i < 3; i++) begin
            esel  = 2'd0;
            edata = rf_data[i*16 +: 16];
            for (int k = 4; k >= 2; k--)
                if (rst_n && m_match(k, i)) begin
                    esel  = 2'(k - 1);
                    edata = res[k];
                end
            chk($sformatf("op_sel[%0d]", i), 64'(op_sel[i*2 +: 2]), 64'(esel));
            chk($sformatf("op_data[%0d]", i), 64'(op_data[i*16 +: 16]), 64'(edata));
        end
        chk("kill", 64'(kill), (!rst_n) ? 64'h0 : flush_in ? 64'h7 : st ? 64'h2 : 64'h0);
        chk("update_s1", 64'(update_s1), 64'(!st));
        chk("stall_cnt", 64'(stall_cnt), 64'((m_stall_n > 65535) ? 65535 : m_stall_n));
        chk("flush_cnt", 64'(flush_cnt), 64'((m_flush_n > 65535) ? 65535 : m_flush_n));
        chk("stall_cnt_w4", 64'(stall_cnt_s), 64'((m_stall_n > 15) ? 15 : m_stall_n));
        chk("flush_cnt_w4", 64'(flush_cnt_s), 64'((m_flush_n > 15) ? 15 : m_flush_n));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_instr(input bit v, input bit [2:0] rd, input bit wr, input bit ld,
                             input bit [2:0] src0, input bit [2:0] use_mask);
        dec_valid = v; dec_rd = rd; dec_wr = wr; dec_ld = ld;
        dec_src = {3'd0, 3'd0, src0}; dec_src_use = use_mask;
    endtask

    task automatic do_reset();
        flush_in = 0;
        set_instr(0, 0, 0, 0, 0, 0);
        rst_n = 0;
        #1;
        model_reset();
        step();
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        rf_data = 48'h3333_2222_1111;
        #2;
        chk("reset update_s1", 64'(update_s1), 64'h1);
        chk("reset kill", 64'(kill), 64'h0);
        chk("reset op_sel", 64'(op_sel), 64'h0);
        chk("reset op_data", 64'(op_data), 64'h3333_2222_1111);
        chk("reset stall_cnt", 64'(stall_cnt), 64'h0);
        step();
        rst_n = 1;

        // Back-to-back ALU forward from S2
        do_reset();
        set_instr(1, 3, 1, 0, 0, 0); step();
        set_instr(1, 0, 0, 0, 3, 3'b001); step();
        set_instr(0, 0, 0, 0, 0, 0); res_s2 = 16'h1234; #1;
        chk("alu op_sel0", 64'(op_sel[1:0]), 64'h1);
        chk("alu op_data0", 64'(op_data[15:0]), 64'h1234);
        chk("alu update_s1", 64'(update_s1), 64'h1);

        // Load-use: two stall cycles, then forward from S4
        do_reset();
        set_instr(1, 5, 1, 1, 0, 0); step();
        set_instr(1, 0, 0, 0, 5, 3'b001); step();
        set_instr(0, 0, 0, 0, 0, 0); #1;
        chk("lu stall1 update_s1", 64'(update_s1), 64'h0);
        chk("lu stall1 kill", 64'(kill), 64'h2);
        step(); #1;
        chk("lu stall2 update_s1", 64'(update_s1), 64'h0);
        chk("lu stall2 kill", 64'(kill), 64'h2);
        step(); wb_data = 16'h5A5A; #1;
        chk("lu fwd op_sel0", 64'(op_sel[1:0]), 64'h3);
        chk("lu fwd op_data0", 64'(op_data[15:0]), 64'h5A5A);
        chk("lu stall_cnt", 64'(stall_cnt), 64'h2);
        chk("lu update_s1", 64'(update_s1), 64'h1);
        step();

        // Three producers of r2: youngest wins
        do_reset();
        for (int n = 0; n < 3; n++) begin set_instr(1, 2, 1, 0, 0, 0); step(); end
        set_instr(1, 0, 0, 0, 2, 3'b001); step();
        set_instr(0, 0, 0, 0, 0, 0);
        res_s2 = 16'hAAAA; res_s3 = 16'hBBBB; wb_data = 16'hCCCC; #1;
        chk("multi op_data0", 64'(op_data[15:0]), 64'hAAAA);
        chk("multi op_sel0", 64'(op_sel[1:0]), 64'h1);

        // Flush during a load-use stall; decode slot must be discarded
        do_reset();
        set_instr(1, 5, 1, 0, 0, 0); step();
        set_instr(1, 5, 1, 1, 0, 0); step();
        set_instr(1, 0, 0, 0, 5, 3'b001); step();
        flush_in = 1; #1;
        chk("flush kill", 64'(kill), 64'h7);
        chk("flush update_s1", 64'(update_s1), 64'h1);
        step();
        flush_in = 0; set_instr(0, 0, 0, 0, 0, 0); #1;
        chk("flush flush_cnt", 64'(flush_cnt), 64'h1);
        chk("flush stall_cnt", 64'(stall_cnt), 64'h0);
        chk("flush S1 empty op_sel0", 64'(op_sel[1:0]), 64'h0);
        chk("flush after kill", 64'(kill), 64'h0);
        step();

        // Asynchronous reset in the middle of a stall
        do_reset();
        set_instr(1, 5, 1, 1, 0, 0); step();
        set_instr(1, 0, 0, 0, 5, 3'b001); step();
        step();
        #2; rst_n = 0; #1; model_reset();
        chk("midrst stall_cnt", 64'(stall_cnt), 64'h0);
        chk("midrst update_s1", 64'(update_s1), 64'h1);
        chk("midrst kill", 64'(kill), 64'h0);
        chk("midrst op_sel", 64'(op_sel), 64'h0);
        step();
        rst_n = 1;
        set_instr(1, 0, 0, 0, 5, 3'b001); step();
        set_instr(0, 0, 0, 0, 0, 0); #1;
        chk("postrst op_sel0", 64'(op_sel[1:0]), 64'h0);
        chk("postrst update_s1", 64'(update_s1), 64'h1);

        // Chain of dependent loads drives the narrow counter to saturation
        do_reset();
        set_instr(1, 5, 1, 1, 5, 3'b001);
        for (int n = 0; n < 40; n++) step();
        set_instr(0, 0, 0, 0, 0, 0); #1;
        chk("sat stall_cnt_w4", 64'(stall_cnt_s), 64'hF);
        for (int n = 0; n < 4; n++) step();
        chk("sat hold stall_cnt_w4", 64'(stall_cnt_s), 64'hF);

        // Randomized traffic with occasional flushes and asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            dec_valid   = ($urandom_range(0, 4) != 0);
            dec_src     = 9'($urandom);
            dec_src_use = 3'($urandom);
            dec_rd      = 3'($urandom);
            dec_wr      = ($urandom_range(0, 3) != 0);
            dec_ld      = ($urandom_range(0, 2) == 0);
            flush_in    = ($urandom_range(0, 9) == 0);
            rf_data     = {16'($urandom), 16'($urandom), 16'($urandom)};
            res_s2      = 16'($urandom);
            res_s3      = 16'($urandom);
            wb_data     = 16'($urandom);
            if (!rst_n) begin
                rst_n = 1;
            end else if ($urandom_range(0, 199) == 0) begin
                #2; rst_n = 0; #1; model_reset();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
